// File: rtl/mem_reader_mac.sv
// Dot-product reader: streams N element pairs from two 1-cycle-latency memories and accumulates a*b.
// Build option: define MEM_READER_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; len sampled on accept
// READ  | issuing reads at addresses 0..N-1
// DRAIN | accumulating the last element returned by memory
// HOLD  | result_valid high until result_ready

module mem_reader_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  rd_en_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [DATA_WIDTH-1:0] dout_a,
  output logic                  rd_en_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] dout_b,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   N_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH:0]     n_q, n_clamp;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    valid_q;
  logic                    done_q;
  logic [ACC_WIDTH-1:0]    acc_q, acc_nx;
  logic                    last_addr;
  logic                    accept;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH:0]      prod_ext, sum;

  assign n_clamp   = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_addr = ({1'b0, addr_q} == (n_q - N_ONE));
  assign accept    = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (n_clamp == '0) ? HOLD : READ;
      READ:    if (last_addr) state_nx = DRAIN;
      DRAIN:   state_nx = HOLD;
      HOLD:    if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Unsigned product, widened by one bit so an overflow carry is visible.
  assign prod     = {{DATA_WIDTH{1'b0}}, dout_a} * {{DATA_WIDTH{1'b0}}, dout_b};
  assign prod_ext = (ACC_WIDTH+1)'(prod);
  assign sum      = {1'b0, acc_q} + prod_ext;

  always_comb begin
    acc_nx = sum[ACC_WIDTH-1:0];
`ifdef MEM_READER_MAC_SATURATE_EN
    if (sum[ACC_WIDTH]) acc_nx = '1;
`else
    acc_nx = sum[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q     <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      valid_q <= (state == READ);
      done_q  <= (state == HOLD) && result_ready;
      if (accept) begin
        n_q    <= n_clamp;
        addr_q <= '0;
        acc_q  <= '0;
      end else begin
        if ((state == READ) && !last_addr) addr_q <= addr_q + ADDR_ONE;
        if (valid_q) acc_q <= acc_nx;
      end
    end
  end

  assign rd_en_a      = (state == READ);
  assign rd_en_b      = (state == READ);
  assign rd_addr_a    = addr_q;
  assign rd_addr_b    = addr_q;
  assign result       = acc_q;
  assign result_valid = (state == HOLD);
  assign busy         = (state != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_mem_reader_mac.sv
// Bench for mem_reader_mac: directed and random dot products against a sum-of-products model.
// Runs a default-width instance and a 16-bit-accumulator instance side by side.

module tb_mem_reader_mac;

  logic        clk = 1'b0;
  logic        rst_n, start, result_ready;
  logic [5:0]  len;
  logic        rd_en_a, rd_en_b, result_valid, busy, done;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [7:0]  dout_a, dout_b;
  logic [20:0] result;
  logic        rd_en_a16, rd_en_b16, result_valid16, busy16, done16;
  logic [4:0]  rd_addr_a16, rd_addr_b16;
  logic [7:0]  dout_a16, dout_b16;
  logic [15:0] result16;

  logic [7:0]  mem_a [32];
  logic [7:0]  mem_b [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_reader_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .dout_a(dout_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .dout_b(dout_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .done(done)
  );

  mem_reader_mac #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .rd_en_a(rd_en_a16), .rd_addr_a(rd_addr_a16), .dout_a(dout_a16),
    .rd_en_b(rd_en_b16), .rd_addr_b(rd_addr_b16), .dout_b(dout_b16),
    .result(result16), .result_valid(result_valid16), .result_ready(result_ready),
    .busy(busy16), .done(done16)
  );

  // One-cycle-latency memories
  always @(posedge clk) begin
    if (rd_en_a)   dout_a   <= mem_a[rd_addr_a];
    if (rd_en_b)   dout_b   <= mem_b[rd_addr_b];
    if (rd_en_a16) dout_a16 <= mem_a[rd_addr_a16];
    if (rd_en_b16) dout_b16 <= mem_b[rd_addr_b16];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input int l, input int w);
    longint s = 0;
    longint lim = (longint'(1) << w);
    int n = (l > 32) ? 32 : l;
    for (int i = 0; i < n; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
`ifdef MEM_READER_MAC_SATURATE_EN
    if (s > lim - 1) s = lim - 1;
`else
    s = s % lim;
`endif
    return 64'(s);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = v;
      mem_b[i] = v;
    end
  endtask

  task automatic do_op(input int l, input int hold, input bit start_in_hold, input bit start_with_ready);
    int n = (l > 32) ? 32 : l;
    int k;
    int reads;
    logic [63:0] exp   = model(l, 21);
    logic [63:0] exp16 = model(l, 16);
    @(negedge clk);
    start = 1'b1;
    len   = 6'(l);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    reads = 0;
    while (!result_valid && k < 200) begin
      chk("rd_en_a", rd_en_a, (k <= n));
      chk("rd_en_b", rd_en_b, (k <= n));
      if (k <= n) begin
        chk("rd_addr_a", rd_addr_a, k - 1);
        chk("rd_addr_b", rd_addr_b, k - 1);
        reads++;
      end
      chk("busy_run", busy, 1);
      @(negedge clk);
      k++;
    end
    chk("valid_latency", k, (n == 0) ? 1 : n + 2);
    chk("read_count", reads, n);
    chk("result", result, exp);
    chk("result16", result16, exp16);
    chk("valid16", result_valid16, 1);
    chk("done_early", done, 0);
    for (int h = 0; h < hold; h++) begin
      start = start_in_hold && (h == 1);
      len   = 6'd3;
      @(negedge clk);
      start = 1'b0;
      chk("hold_result", result, exp);
      chk("hold_valid", result_valid, 1);
      chk("hold_rd_en", rd_en_a, 0);
      chk("hold_done", done, 0);
    end
    result_ready = 1'b1;
    start = start_with_ready;
    len   = 6'd3;
    @(negedge clk);
    result_ready = 1'b0;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done16", done16, 1);
    chk("idle_valid", result_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_busy16", busy16, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("start_ignored", busy, 0);
    chk("idle_rd_en", rd_en_a, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    result_ready = 1'b0;
    fill_const(8'd0);
    repeat (2) @(negedge clk);
    chk("rst_rd_en_a", rd_en_a, 0);
    chk("rst_rd_en_b", rd_en_b, 0);
    chk("rst_addr_a", rd_addr_a, 0);
    chk("rst_addr_b", rd_addr_b, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    do_op(4, 0, 0, 0);
    chk("dot_1234_5678", result, 70);

    fill_random();
    do_op(0, 0, 0, 0);

    fill_const(8'd255);
    do_op(40, 0, 0, 0);
    do_op(2, 0, 0, 0);

    fill_random();
    do_op(int'($urandom_range(1, 12)), 5, 1, 1);

    // Reset after the second read cycle aborts the operation
    fill_random();
    @(negedge clk);
    start = 1'b1;
    len = 6'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", rd_en_a, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_result", result, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_result", result_valid, 0);
    end
    do_op(4, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_op(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_reader_mac.md
MEM_READER_MAC -- requirements
Module: mem_reader_mac

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of each memory element.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, the width of the memory read address.
REQ-003 The block SHALL have parameter DEPTH, default 32, the maximum number of elements per vector.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+ADDR_WIDTH, the accumulator and result width.
REQ-005 The block SHALL have these ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  request to compute one dot product.
- len  input  ADDR_WIDTH+1  element count, sampled when start is accepted.
- rd_en_a  output  1  read enable to memory A.
- rd_addr_a  output  ADDR_WIDTH  read address to memory A.
- dout_a  input  DATA_WIDTH  memory A read data.
- rd_en_b  output  1  read enable to memory B.
- rd_addr_b  output  ADDR_WIDTH  read address to memory B.
- dout_b  input  DATA_WIDTH  memory B read data.
- result  output  ACC_WIDTH  dot product, unsigned.
- result_valid  output  1  result is held and valid.
- result_ready  input  1  consumer accepts result.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result is accepted.

Function
REQ-006 The FSM SHALL have four states: IDLE, READ, DRAIN and HOLD.
REQ-007 In IDLE, start=1 SHALL be accepted at that edge. The block SHALL latch min(len,DEPTH) as N, clear the accumulator and the address, and go to READ; with N=0 it SHALL go directly to HOLD with result=0.
REQ-008 In READ, rd_en_a and rd_en_b SHALL both be high for exactly N consecutive cycles. rd_addr_a and rd_addr_b SHALL be equal and SHALL step 0,1,...,N-1, one per cycle. After the cycle with address N-1 the FSM SHALL go to DRAIN.
REQ-009 Memory read latency is one cycle: dout_a and dout_b are valid in the cycle after rd_en. A one-bit valid pipe, rd_en delayed by one cycle, SHALL qualify accumulation.
REQ-010 When the valid pipe is set, the block SHALL perform acc <= acc + dout_a*dout_b. The product SHALL be unsigned and 2*DATA_WIDTH wide, zero-extended to ACC_WIDTH.
REQ-011 DRAIN SHALL last one cycle, accumulate the final element, and then go to HOLD.
REQ-012 In HOLD, result_valid SHALL be 1 and result SHALL equal acc, stable until accepted.
- result_valid rises N+2 cycles after the start-accept edge.
- At the edge where result_valid and result_ready are both 1, the FSM SHALL go to IDLE and done SHALL pulse high for the following cycle.
REQ-013 start SHALL be ignored in every state except IDLE, including start and result_ready asserted in the same cycle in HOLD.
REQ-014 rd_en_a and rd_en_b SHALL be 0 in IDLE, DRAIN and HOLD, and rd_addr SHALL hold its last value.
REQ-015 Without the configured feature, the accumulator SHALL wrap modulo 2^ACC_WIDTH.

Reset
REQ-016 When rst_n=0 at a rising clk edge, the block SHALL go to IDLE and set acc=0, address=0, N=0 and valid pipe=0. All outputs (rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, result, result_valid, busy, done) SHALL be 0.
REQ-017 A reset in any state, including mid-READ, SHALL abort the operation: rd_en SHALL be 0 in the cycle after the reset edge, and no result SHALL be produced.

Configuration
REQ-018 Macro MEM_READER_MAC_SATURATE_EN SHALL select the accumulator overflow behaviour.
- Defined: an addition that would exceed 2^ACC_WIDTH-1 SHALL clamp acc to all-ones, and acc SHALL stay there until the next start.
- Undefined: wrap per REQ-015.
- Ports and timing SHALL be identical in both builds.

Verification
REQ-019 A bench SHALL cover these scenarios:
- A=[1,2,3,4], B=[5,6,7,8], len=4, result_ready=1 -> rd_en high 4 cycles at addresses 0..3; result=70 and result_valid at start+6; done pulses once.
- len=0 -> no rd_en; result_valid=1 with result=0 one cycle after start.
- len=40, all elements 255, defaults -> exactly 32 reads; result=2080800.
- ACC_WIDTH=16, len=2, A=B=[255,255] -> with macro, result=65535; without macro, result=64514.
- result_ready held 0 for 5 cycles in HOLD, start pulsed during HOLD -> result stable, start ignored, done only after ready.
- rst_n=0 after the 2nd read cycle -> next cycle rd_en=0, busy=0, result_valid=0; a following start computes correctly.
